// File: rtl/riscv_trap_sequencer.sv
// -----------------------------------------------------------------------------
// riscv_trap_sequencer
//
// Machine-mode trap / MRET controller for the RV64IMC core.
//
// In IDLE the block looks at the execute-stage instruction. If that
// instruction raises an exception, or an enabled interrupt is pending, it
// picks one trap by fixed priority and squashes the instruction with kill.
// It then writes mepc, mcause, mtval and mstatus through the single CSR
// write port, one CSR per state, while stalling the pipeline. An MRET runs
// a single mstatus write instead. Both sequences end in one REDIRECT cycle
// that flushes IF/ID/EX and loads the new PC.
//
// Ports
//   i_riscv_trap_clk / i_riscv_trap_rst_n  clock, synchronous active-low reset
//   i_riscv_trap_valid, _pc, _instr, _addr execute-stage instruction info
//   i_riscv_trap_*_misaligned, _illegal,
//   _ecall, _ebreak, _mret                 exception / decoder flags
//   i_riscv_trap_mip, _mie                 pending / enabled interrupts
//   i_riscv_trap_mstatus, _mtvec, _mepc    current CSR values
//   i_riscv_trap_csr_ready                 CSR file accepts the write
//   o_riscv_trap_kill                      squash current instruction (comb)
//   o_riscv_trap_stall                     freeze pipeline (all non-IDLE states)
//   o_riscv_trap_csr_wen/_addr/_wdata      CSR write port
//   o_riscv_trap_flush, _redirect, _target pipeline flush and PC redirect
// -----------------------------------------------------------------------------
module riscv_trap_sequencer #(
    parameter int XLEN = 64
) (
    input  logic            i_riscv_trap_clk,
    input  logic            i_riscv_trap_rst_n,
    input  logic            i_riscv_trap_valid,
    input  logic [XLEN-1:0] i_riscv_trap_pc,
    input  logic [31:0]     i_riscv_trap_instr,
    input  logic [XLEN-1:0] i_riscv_trap_addr,
    input  logic            i_riscv_trap_inst_addr_misaligned,
    input  logic            i_riscv_trap_load_addr_misaligned,
    input  logic            i_riscv_trap_store_addr_misaligned,
    input  logic            i_riscv_trap_illegal,
    input  logic            i_riscv_trap_ecall,
    input  logic            i_riscv_trap_ebreak,
    input  logic            i_riscv_trap_mret,
    input  logic [XLEN-1:0] i_riscv_trap_mip,
    input  logic [XLEN-1:0] i_riscv_trap_mie,
    input  logic [XLEN-1:0] i_riscv_trap_mstatus,
    input  logic [XLEN-1:0] i_riscv_trap_mtvec,
    input  logic [XLEN-1:0] i_riscv_trap_mepc,
    input  logic            i_riscv_trap_csr_ready,
    output logic            o_riscv_trap_kill,
    output logic            o_riscv_trap_stall,
    output logic            o_riscv_trap_csr_wen,
    output logic [11:0]     o_riscv_trap_csr_addr,
    output logic [XLEN-1:0] o_riscv_trap_csr_wdata,
    output logic            o_riscv_trap_flush,
    output logic            o_riscv_trap_redirect,
    output logic [XLEN-1:0] o_riscv_trap_target
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    // Interrupt sources, entry 0 has the highest priority: MEI > MSI > MTI.
    localparam int NUM_INT = 3;
    localparam logic [NUM_INT-1:0][3:0] INT_CODE = {4'd7, 4'd3, 4'd11};

    // Exception sources, entry 0 has the highest priority:
    // illegal > inst misaligned > ebreak > ecall > store misaligned > load misaligned.
    localparam int NUM_EXC = 6;
    localparam logic [NUM_EXC-1:0][3:0] EXC_CODE = {4'd4, 4'd6, 4'd11, 4'd3, 4'd0, 4'd2};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_EPC,
        ST_WR_CAUSE,
        ST_WR_TVAL,
        ST_WR_STATUS,
        ST_MRET_STATUS,
        ST_REDIRECT
    } state_t;

    state_t          state_reg, state_next;
    logic [XLEN-1:0] epc_reg, epc_next;
    logic [XLEN-1:0] cause_reg, cause_next;
    logic [XLEN-1:0] tval_reg, tval_next;
    logic [XLEN-1:0] target_reg, target_next;

    logic [NUM_INT-1:0] int_hit;
    logic [NUM_EXC-1:0] exc_flag;
    logic               is_int;
    logic               trap_pending;
    logic               accept_trap;
    logic               accept_mret;
    logic [3:0]         int_code;
    logic [3:0]         exc_code;
    logic [3:0]         sel_code;
    logic [XLEN-1:0]    trap_cause;
    logic [XLEN-1:0]    trap_tval;
    logic [XLEN-1:0]    trap_base;
    logic [XLEN-1:0]    trap_target;

    // Only bits 3, 7 and 11 of mip/mie matter; the rest are folded here.
    logic unused_bits;
    assign unused_bits = ^{i_riscv_trap_mip, i_riscv_trap_mie};

    // An interrupt line counts only when globally enabled via mstatus.MIE.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INT; gi++) begin : g_int_hit
            assign int_hit[gi] = i_riscv_trap_mstatus[3]
                               & i_riscv_trap_mip[INT_CODE[gi]]
                               & i_riscv_trap_mie[INT_CODE[gi]];
        end
    endgenerate

    assign exc_flag = {i_riscv_trap_load_addr_misaligned,
                       i_riscv_trap_store_addr_misaligned,
                       i_riscv_trap_ecall,
                       i_riscv_trap_ebreak,
                       i_riscv_trap_inst_addr_misaligned,
                       i_riscv_trap_illegal};

    assign is_int       = |int_hit;
    assign trap_pending = is_int | (|exc_flag);
    assign accept_trap  = (state_reg == ST_IDLE) & i_riscv_trap_valid & trap_pending;
    assign accept_mret  = (state_reg == ST_IDLE) & i_riscv_trap_valid & i_riscv_trap_mret
                        & ~trap_pending;

    // Priority encoders: walk from lowest to highest priority so the
    // highest-priority set source is the last one to write the code.
    always_comb begin
        int_code = 4'd0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (int_hit[i]) begin
                int_code = INT_CODE[i];
            end
        end
    end

    always_comb begin
        exc_code = 4'd0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_flag[i]) begin
                exc_code = EXC_CODE[i];
            end
        end
    end

    assign sel_code   = is_int ? int_code : exc_code;
    assign trap_cause = {is_int, {(XLEN-5){1'b0}}, sel_code};

    always_comb begin
        trap_tval = '0;
        if (!is_int) begin
            case (exc_code)
                4'd0, 4'd4, 4'd6: trap_tval = i_riscv_trap_addr;
                4'd2:             trap_tval = {{(XLEN-32){1'b0}}, i_riscv_trap_instr};
                4'd3:             trap_tval = i_riscv_trap_pc;
                default:          trap_tval = '0;
            endcase
        end
    end

    // Vectored mode only offsets interrupts; exceptions always use the base.
    assign trap_base   = {i_riscv_trap_mtvec[XLEN-1:2], 2'b00};
    assign trap_target = ((i_riscv_trap_mtvec[1:0] == 2'b01) && is_int)
                       ? trap_base + {{(XLEN-6){1'b0}}, sel_code, 2'b00}
                       : trap_base;

    function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] s);
        logic [XLEN-1:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    always_ff @(posedge i_riscv_trap_clk) begin
        if (!i_riscv_trap_rst_n) begin
            state_reg  <= ST_IDLE;
            epc_reg    <= '0;
            cause_reg  <= '0;
            tval_reg   <= '0;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            epc_reg    <= epc_next;
            cause_reg  <= cause_next;
            tval_reg   <= tval_next;
            target_reg <= target_next;
        end
    end

    always_comb begin
        state_next             = state_reg;
        epc_next               = epc_reg;
        cause_next             = cause_reg;
        tval_next              = tval_reg;
        target_next            = target_reg;
        o_riscv_trap_kill      = 1'b0;
        o_riscv_trap_stall     = 1'b0;
        o_riscv_trap_csr_wen   = 1'b0;
        o_riscv_trap_csr_addr  = 12'h000;
        o_riscv_trap_csr_wdata = '0;
        o_riscv_trap_flush     = 1'b0;
        o_riscv_trap_redirect  = 1'b0;
        o_riscv_trap_target    = '0;

        case (state_reg)
            ST_IDLE: begin
                o_riscv_trap_kill = accept_trap | accept_mret;
                if (accept_trap) begin
                    state_next  = ST_WR_EPC;
                    epc_next    = i_riscv_trap_pc;
                    cause_next  = trap_cause;
                    tval_next   = trap_tval;
                    target_next = trap_target;
                end else if (accept_mret) begin
                    state_next  = ST_MRET_STATUS;
                    target_next = i_riscv_trap_mepc;
                end
            end

            ST_WR_EPC: begin
                o_riscv_trap_stall     = 1'b1;
                o_riscv_trap_csr_wen   = 1'b1;
                o_riscv_trap_csr_addr  = CSR_MEPC;
                o_riscv_trap_csr_wdata = epc_reg;
                if (i_riscv_trap_csr_ready) begin
                    state_next = ST_WR_CAUSE;
                end
            end

            ST_WR_CAUSE: begin
                o_riscv_trap_stall     = 1'b1;
                o_riscv_trap_csr_wen   = 1'b1;
                o_riscv_trap_csr_addr  = CSR_MCAUSE;
                o_riscv_trap_csr_wdata = cause_reg;
                if (i_riscv_trap_csr_ready) begin
                    state_next = ST_WR_TVAL;
                end
            end

            ST_WR_TVAL: begin
                o_riscv_trap_stall     = 1'b1;
                o_riscv_trap_csr_wen   = 1'b1;
                o_riscv_trap_csr_addr  = CSR_MTVAL;
                o_riscv_trap_csr_wdata = tval_reg;
                if (i_riscv_trap_csr_ready) begin
                    state_next = ST_WR_STATUS;
                end
            end

            // mstatus is read live here so the write reflects its current value.
            ST_WR_STATUS: begin
                o_riscv_trap_stall     = 1'b1;
                o_riscv_trap_csr_wen   = 1'b1;
                o_riscv_trap_csr_addr  = CSR_MSTATUS;
                o_riscv_trap_csr_wdata = trap_status(i_riscv_trap_mstatus);
                if (i_riscv_trap_csr_ready) begin
                    state_next = ST_REDIRECT;
                end
            end

            ST_MRET_STATUS: begin
                o_riscv_trap_stall     = 1'b1;
                o_riscv_trap_csr_wen   = 1'b1;
                o_riscv_trap_csr_addr  = CSR_MSTATUS;
                o_riscv_trap_csr_wdata = mret_status(i_riscv_trap_mstatus);
                if (i_riscv_trap_csr_ready) begin
                    state_next = ST_REDIRECT;
                end
            end

            ST_REDIRECT: begin
                o_riscv_trap_stall    = 1'b1;
                o_riscv_trap_flush    = 1'b1;
                o_riscv_trap_redirect = 1'b1;
                o_riscv_trap_target   = target_reg;
                state_next            = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_riscv_trap_sequencer
//
// Directed table of trap/MRET scenarios with hand-computed expectations,
// a reset-abort sequence, then randomized transactions whose expectations
// come from a rule-level reference model. One line is printed per
// transaction and a single summary line at the end.
// -----------------------------------------------------------------------------
module tb_riscv_trap_sequencer;

    // flags bit order: {mret, ebreak, ecall, illegal, store_mis, load_mis, inst_mis}
    typedef struct {
        logic        valid;
        logic [63:0] pc;
        logic [31:0] instr;
        logic [63:0] addr;
        logic [6:0]  flags;
        logic [63:0] mip;
        logic [63:0] mie;
        logic [63:0] mstatus;
        logic [63:0] mtvec;
        logic [63:0] mepc;
        int          hold_idx;    // write index to hold csr_ready low at; -1 none, -2 random
        int          hold_cycles;
        int          kind;        // 0 none, 1 trap, 2 mret
        logic [63:0] cause;
        logic [63:0] tval;
        logic [63:0] status;
        logic [63:0] target;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] addr;
    logic        inst_mis, load_mis, store_mis, illegal, ecall, ebreak, mret;
    logic [63:0] mip, mie, mstatus, mtvec, mepc;
    logic        csr_ready;
    logic        kill, stall, csr_wen, flush, redirect;
    logic [11:0] csr_addr;
    logic [63:0] csr_wdata, target;

    int checks_total  = 0;
    int checks_passed = 0;
    int txn_id        = 0;

    riscv_trap_sequencer dut (
        .i_riscv_trap_clk                  (clk),
        .i_riscv_trap_rst_n                (rst_n),
        .i_riscv_trap_valid                (valid),
        .i_riscv_trap_pc                   (pc),
        .i_riscv_trap_instr                (instr),
        .i_riscv_trap_addr                 (addr),
        .i_riscv_trap_inst_addr_misaligned (inst_mis),
        .i_riscv_trap_load_addr_misaligned (load_mis),
        .i_riscv_trap_store_addr_misaligned(store_mis),
        .i_riscv_trap_illegal              (illegal),
        .i_riscv_trap_ecall                (ecall),
        .i_riscv_trap_ebreak               (ebreak),
        .i_riscv_trap_mret                 (mret),
        .i_riscv_trap_mip                  (mip),
        .i_riscv_trap_mie                  (mie),
        .i_riscv_trap_mstatus              (mstatus),
        .i_riscv_trap_mtvec                (mtvec),
        .i_riscv_trap_mepc                 (mepc),
        .i_riscv_trap_csr_ready            (csr_ready),
        .o_riscv_trap_kill                 (kill),
        .o_riscv_trap_stall                (stall),
        .o_riscv_trap_csr_wen              (csr_wen),
        .o_riscv_trap_csr_addr             (csr_addr),
        .o_riscv_trap_csr_wdata            (csr_wdata),
        .o_riscv_trap_flush                (flush),
        .o_riscv_trap_redirect             (redirect),
        .o_riscv_trap_target               (target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mkv(input logic v, input logic [63:0] p, input logic [31:0] ins,
                                 input logic [63:0] a, input logic [6:0] f,
                                 input logic [63:0] ip, input logic [63:0] ie,
                                 input logic [63:0] ms, input logic [63:0] tv,
                                 input logic [63:0] ep, input int hi, input int hc,
                                 input int k, input logic [63:0] c, input logic [63:0] tl,
                                 input logic [63:0] st, input logic [63:0] tg);
        vec_t r;
        r.valid = v;  r.pc = p;  r.instr = ins; r.addr = a; r.flags = f;
        r.mip = ip;   r.mie = ie; r.mstatus = ms; r.mtvec = tv; r.mepc = ep;
        r.hold_idx = hi; r.hold_cycles = hc;
        r.kind = k; r.cause = c; r.tval = tl; r.status = st; r.target = tg;
        return r;
    endfunction

    // Reference model: evaluates the trap rules directly on the inputs.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        logic [63:0] ie;
        logic [63:0] code;
        bit          is_int;
        bit          trap;
        r = v;
        r.kind = 0; r.cause = 0; r.tval = 0; r.status = 0; r.target = 0;
        ie     = v.mstatus[3] ? (v.mip & v.mie) : 64'h0;
        code   = 0;
        trap   = 1;
        is_int = 1;
        if (ie[11])      code = 11;
        else if (ie[3])  code = 3;
        else if (ie[7])  code = 7;
        else begin
            is_int = 0;
            if (v.flags[3])      begin code = 2;  r.tval = {32'h0, v.instr}; end
            else if (v.flags[0]) begin code = 0;  r.tval = v.addr; end
            else if (v.flags[5]) begin code = 3;  r.tval = v.pc; end
            else if (v.flags[4]) begin code = 11; end
            else if (v.flags[2]) begin code = 6;  r.tval = v.addr; end
            else if (v.flags[1]) begin code = 4;  r.tval = v.addr; end
            else trap = 0;
        end
        if (!v.valid) trap = 0;
        if (trap) begin
            r.kind   = 1;
            r.cause  = (is_int ? 64'h8000_0000_0000_0000 : 64'h0) + code;
            r.status = (v.mstatus & ~64'h1888) | 64'h1800 | (v.mstatus[3] ? 64'h80 : 64'h0);
            r.target = (v.mtvec & ~64'h3)
                     + ((v.mtvec[1:0] == 2'b01 && is_int) ? code * 4 : 64'h0);
        end else begin
            r.tval = 0;
            if (v.valid && v.flags[6]) begin
                r.kind   = 2;
                r.status = (v.mstatus & ~64'h1888) | 64'h1880 | (v.mstatus[7] ? 64'h8 : 64'h0);
                r.target = v.mepc;
            end
        end
        return r;
    endfunction

    task automatic drive(input vec_t v);
        valid   = v.valid;  pc = v.pc;  instr = v.instr;  addr = v.addr;
        inst_mis  = v.flags[0]; load_mis = v.flags[1]; store_mis = v.flags[2];
        illegal   = v.flags[3]; ecall    = v.flags[4]; ebreak    = v.flags[5];
        mret      = v.flags[6];
        mip = v.mip; mie = v.mie; mstatus = v.mstatus; mtvec = v.mtvec; mepc = v.mepc;
    endtask

    task automatic clear_flags();
        valid = 1'b0; inst_mis = 1'b0; load_mis = 1'b0; store_mis = 1'b0;
        illegal = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0;
    endtask

    // Runs one transaction starting in IDLE. Leaves the DUT in its REDIRECT
    // cycle (or one cycle after a non-accepted input) with flags cleared, so
    // the next call's accept lands in the cycle right after REDIRECT.
    task automatic run_vec(input vec_t v);
        logic [11:0] exp_a [4];
        logic [63:0] exp_d [4];
        int          nexp, nwr, nr, held, ncyc;
        bit          got;
        logic [63:0] r_target;
        logic        r_flush;

        nexp = 0; nwr = 0; nr = 0; held = 0; ncyc = 0; got = 0;
        r_target = 0; r_flush = 0;
        if (v.kind == 1) begin
            exp_a[0] = 12'h341; exp_d[0] = v.pc;
            exp_a[1] = 12'h342; exp_d[1] = v.cause;
            exp_a[2] = 12'h343; exp_d[2] = v.tval;
            exp_a[3] = 12'h300; exp_d[3] = v.status;
            nexp = 4;
        end else if (v.kind == 2) begin
            exp_a[0] = 12'h300; exp_d[0] = v.status;
            nexp = 1;
        end

        @(negedge clk);
        drive(v);
        csr_ready = 1'b1;
        #1;
        chk("t0_kill", {63'h0, kill}, (v.kind != 0) ? 64'h1 : 64'h0);
        chk("t0_stall", {63'h0, stall}, 64'h0);
        chk("t0_csr_wen", {63'h0, csr_wen}, 64'h0);
        chk("t0_redirect", {63'h0, redirect}, 64'h0);
        chk("t0_flush", {63'h0, flush}, 64'h0);

        if (v.kind == 0) begin
            @(negedge clk);
            clear_flags();
            #1;
            chk("noacc_stall", {63'h0, stall}, 64'h0);
            chk("noacc_csr_wen", {63'h0, csr_wen}, 64'h0);
            $display("txn %0d: no trap accepted (valid=%0b flags=%b)", txn_id, v.valid, v.flags);
            txn_id++;
            return;
        end

        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            // Garbage on the execute-stage inputs; the sequencer must ignore it.
            valid = 1'b1;
            {mret, ebreak, ecall, illegal, store_mis, load_mis, inst_mis} = 7'($urandom);
            pc    = {$urandom(), $urandom()};
            addr  = {$urandom(), $urandom()};
            instr = $urandom();
            mip   = '1;
            mie   = '1;
            if (v.hold_idx == -2) begin
                csr_ready = ($urandom_range(0, 3) != 0);
            end else if (nwr == v.hold_idx && held < v.hold_cycles) begin
                csr_ready = 1'b0;
                held++;
            end else begin
                csr_ready = 1'b1;
            end
            #1;
            chk("seq_stall", {63'h0, stall}, 64'h1);
            chk("seq_kill", {63'h0, kill}, 64'h0);
            if (csr_wen) begin
                if (nwr < nexp) begin
                    chk("wr_addr", {52'h0, csr_addr}, {52'h0, exp_a[nwr]});
                    chk("wr_data", csr_wdata, exp_d[nwr]);
                end else begin
                    chk("extra_write", 64'(nwr), 64'(nexp - 1));
                end
                if (csr_ready) nwr++;
                else           nr++;
            end
            if (redirect) begin
                got      = 1;
                ncyc     = c;
                r_target = target;
                r_flush  = flush;
                break;
            end else begin
                chk("flush_early", {63'h0, flush}, 64'h0);
            end
        end
        clear_flags();
        csr_ready = 1'b1;

        if (!got) begin
            chk("redirect_timeout", 64'h0, 64'h1);
        end else begin
            chk("n_writes", 64'(nwr), 64'(nexp));
            chk("redirect_target", r_target, v.target);
            chk("redirect_flush", {63'h0, r_flush}, 64'h1);
            chk("redirect_cycle", 64'(ncyc), 64'(nexp + 1 + nr));
        end
        $display("txn %0d: kind=%0d cause=%h tval=%h target=%h redirect_at=T%0d",
                 txn_id, v.kind, v.cause, v.tval, v.target, ncyc);
        txn_id++;
    endtask

    vec_t tbl [13];
    vec_t rv;

    initial begin
        tbl[0]  = mkv(1, 64'h1000, 32'h0, 64'h2003, 7'b0000010, 64'h0, 64'h0, 64'h8, 64'h8000, 64'h0,
                      -1, 0, 1, 64'h4, 64'h2003, 64'h1880, 64'h8000);
        tbl[1]  = mkv(1, 64'h2000, 32'hDEADBEEF, 64'h3001, 7'b0001100, 64'h800, 64'h800, 64'h8,
                      64'h8001, 64'h0, -1, 0, 1, 64'h8000_0000_0000_000B, 64'h0, 64'h1880, 64'h802C);
        tbl[2]  = mkv(1, 64'h3FFC, 32'h0, 64'h0, 7'b1000000, 64'h0, 64'h0, 64'h80, 64'h8000, 64'h4000,
                      -1, 0, 2, 64'h0, 64'h0, 64'h1888, 64'h4000);
        tbl[3]  = mkv(1, 64'h3000, 32'h0, 64'h0, 7'b0010000, 64'h0, 64'h0, 64'h0, 64'h8001, 64'h0,
                      1, 3, 1, 64'hB, 64'h0, 64'h1800, 64'h8000);
        tbl[4]  = mkv(1, 64'h3100, 32'h0, 64'h0, 7'b0000000, 64'h80, 64'h80, 64'h0, 64'h8000, 64'h0,
                      -1, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        tbl[5]  = mkv(0, 64'h3200, 32'h0, 64'h0, 7'b0010000, 64'h0, 64'h0, 64'h8, 64'h8000, 64'h0,
                      -1, 0, 0, 64'h0, 64'h0, 64'h0, 64'h0);
        tbl[6]  = mkv(1, 64'h3300, 32'hFFFFFFFF, 64'h0, 7'b0001000, 64'h0, 64'h0, 64'hA000_0000_0000_0002,
                      64'h10002, 64'h0, -1, 0, 1, 64'h2, 64'hFFFF_FFFF, 64'hA000_0000_0000_1802, 64'h10000);
        tbl[7]  = mkv(1, 64'h5000, 32'h0, 64'h0, 7'b1100000, 64'h0, 64'h0, 64'h88, 64'h100, 64'h9000,
                      -1, 0, 1, 64'h3, 64'h5000, 64'h1880, 64'h100);
        tbl[8]  = mkv(1, 64'h5100, 32'h0, 64'h0, 7'b0010000, 64'h88, 64'h888, 64'h8,
                      64'hFFFF_FFFF_FFFF_FFFD, 64'h0, -1, 0, 1, 64'h8000_0000_0000_0003, 64'h0,
                      64'h1880, 64'h8);
        tbl[9]  = mkv(1, 64'h6000, 32'h0, 64'h6002, 7'b0100011, 64'h0, 64'h0, 64'h1888, 64'h8000, 64'h0,
                      -1, 0, 1, 64'h0, 64'h6002, 64'h1880, 64'h8000);
        tbl[10] = mkv(1, 64'h6100, 32'h0, 64'h0, 7'b0000000, 64'h80, 64'h80, 64'h8, 64'h201, 64'h0,
                      -1, 0, 1, 64'h8000_0000_0000_0007, 64'h0, 64'h1880, 64'h21C);
        tbl[11] = mkv(1, 64'h6200, 32'h0, 64'h0, 7'b1000000, 64'h0, 64'h0, 64'h8, 64'h8000, 64'hABC0,
                      -1, 0, 2, 64'h0, 64'h0, 64'h1880, 64'hABC0);
        tbl[12] = mkv(1, 64'h6300, 32'h0, 64'h77, 7'b0000110, 64'h0, 64'h0, 64'h0, 64'h8000, 64'h0,
                      -1, 0, 1, 64'h6, 64'h77, 64'h1800, 64'h8000);

        // Reset state.
        rst_n = 1'b0;
        csr_ready = 1'b1;
        clear_flags();
        pc = 0; instr = 0; addr = 0; mip = 0; mie = 0; mstatus = 0; mtvec = 0; mepc = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_stall", {63'h0, stall}, 64'h0);
        chk("rst_csr_wen", {63'h0, csr_wen}, 64'h0);
        chk("rst_csr_addr", {52'h0, csr_addr}, 64'h0);
        chk("rst_csr_wdata", csr_wdata, 64'h0);
        chk("rst_redirect", {63'h0, redirect}, 64'h0);
        chk("rst_flush", {63'h0, flush}, 64'h0);
        chk("rst_target", target, 64'h0);
        chk("rst_kill", {63'h0, kill}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i]);
        end

        // Reset while in WR_TVAL aborts the sequence.
        @(negedge clk);
        drive(tbl[0]);
        csr_ready = 1'b1;
        #1;
        chk("abort_t0_kill", {63'h0, kill}, 64'h1);
        @(negedge clk);
        clear_flags();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("abort_t3_addr", {52'h0, csr_addr}, 64'h343);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_stall", {63'h0, stall}, 64'h0);
        chk("abort_csr_wen", {63'h0, csr_wen}, 64'h0);
        chk("abort_csr_addr", {52'h0, csr_addr}, 64'h0);
        chk("abort_csr_wdata", csr_wdata, 64'h0);
        chk("abort_redirect", {63'h0, redirect}, 64'h0);
        chk("abort_flush", {63'h0, flush}, 64'h0);
        chk("abort_target", target, 64'h0);
        chk("abort_kill", {63'h0, kill}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("abort_quiet_wen", {63'h0, csr_wen}, 64'h0);
            chk("abort_quiet_redirect", {63'h0, redirect}, 64'h0);
        end
        $display("txn %0d: reset during WR_TVAL aborted the trap", txn_id);
        txn_id++;
        run_vec(tbl[0]);

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            rv.valid   = ($urandom_range(0, 7) != 0);
            rv.pc      = {$urandom(), $urandom()};
            rv.instr   = $urandom();
            rv.addr    = {$urandom(), $urandom()};
            for (int b = 0; b < 7; b++) rv.flags[b] = ($urandom_range(0, 5) == 0);
            rv.mip     = {$urandom(), $urandom()} & 64'h888;
            rv.mie     = {$urandom(), $urandom()} & 64'h888;
            rv.mstatus = {$urandom(), $urandom()};
            rv.mtvec   = {$urandom(), $urandom()};
            rv.mepc    = {$urandom(), $urandom()};
            rv.hold_idx    = -2;
            rv.hold_cycles = 0;
            rv = model(rv);
            run_vec(rv);
        end

        @(negedge clk);
        #1;
        chk("final_idle_stall", {63'h0, stall}, 64'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
